sprite_fetch_scheduler: RTL and testbench
=========================================

// Module: sprite_fetch_scheduler
// PURPOSE
//   Shares the single car/sprite bitmap ROM among NUM_SPRITES sprite renderers during horizontal blank.
//   At hblank start it snapshots which renderers need a row fetch, then grants ROM slots one at a time.
//   Each grant is a SLOT_CYCLES-long load window, with round-robin priority rotated each line.
//   It drives each renderer's load input and the shared ROM address mux.
//   It replaces ad-hoc hpos-window decoding in game top levels.
// PARAMETERS
//   NUM_SPRITES   4    number of sprite renderers sharing the ROM (1..8)
//   ADDR_W        4    width of renderer rom_addr / ROM yofs
//   SLOT_CYCLES   4    clocks per load window (>=1)
//   HBLANK_START  256  hpos value that opens the fetch phase
//   MAX_SLOTS     12   maximum grants per line (hblank budget)
// PORTS
//   clk        in   1                    pixel clock
//   reset      in   1                    async, active-high
//   hpos       in   9                    horizontal counter from hvsync_generator
//   req        in   NUM_SPRITES          renderer i needs a fetch this line (its in_progress)
//   addr_in    in   NUM_SPRITES*ADDR_W   renderer i rom_addr at bits [i*ADDR_W +: ADDR_W]
//   load       out  NUM_SPRITES          one-hot load strobe to renderer i, or all zero
//   rom_yofs   out  ADDR_W               address to shared ROM = addr_in slice of granted renderer
//   active_id  out  3                    index of granted renderer (valid while busy)
//   busy       out  1                    1 from entry to ARB until entry to DONE
//   overrun    out  1                    1-clk pulse: line ended with unserved requests
// BEHAVIOUR
//   Reset (async): state=IDLE; load=0, rom_yofs=0, active_id=0, busy=0, overrun=0; rr_ptr=0, pending=0, slots=0, cnt=0.
//   Reset mid-LOAD drops load to 0 immediately.
//   Outputs are registered. rom_yofs is the registered mux of addr_in[active_id], and is 0 when load=0.
//   IDLE: at a clk edge with hpos==HBLANK_START, pending<=req, slots<=0, and go to ARB. Otherwise stay.
//   ARB (1 clk): if pending==0, go to DONE.
//     Otherwise pick the first set pending bit scanning rr_ptr, rr_ptr+1, ... mod NUM_SPRITES.
//     Set active_id, cnt<=0, and go to LOAD.
//   LOAD: load[active_id]=1 for exactly SLOT_CYCLES consecutive clks. cnt counts 0..SLOT_CYCLES-1.
//     On the last cycle: clear pending[active_id] and increment slots.
//     Then go to DONE if (slots+1)==MAX_SLOTS or the remaining pending is 0; otherwise go to ARB.
//     Consecutive grants are therefore separated by one idle ARB cycle with load=0.
//   DONE: on entry, rr_ptr<=(rr_ptr+1) mod NUM_SPRITES.
//     On entry, pulse overrun for 1 clk if pending is still non-zero.
//     Stay in DONE until hpos==0, then go to IDLE.
//   req and addr_in changes after the snapshot do not alter pending.
//     addr_in is sampled live each LOAD cycle.
//   hpos==HBLANK_START while not IDLE is ignored; no restart within a line.
//   The full line (hpos 0..HBLANK_START-1) is never touched: load=0 throughout visible pixels.
//   Per-line cost: 1 + k*(SLOT_CYCLES+1) clks for k grants.
//     The integrator must ensure this fits in hblank for MAX_SLOTS.
//   NUM_SPRITES=1: rr_ptr stays 0; at most one grant per line.
// TESTING
//   1. Assert reset mid-LOAD (hpos=258) -> load=0 and busy=0 the same cycle.
//      After release, no grant occurs until the next hpos==256.
//   2. req=4'b0101, rr_ptr=0, hpos reaches 256.
//      -> load=0001 for clks 258-261, idle at 262, load=0100 for 263-266, DONE at 267, overrun=0.
//   3. Next line with req=4'b0101 (rr_ptr=1) -> sprite 2 is granted first, then sprite 0.
//   4. MAX_SLOTS=2, req=4'b1111 -> exactly 2 grants, then overrun pulses once.
//      Next line starts at rr_ptr+1.
//   5. req=0 at hpos 256 -> busy for 1 clk (ARB), no load, no overrun, DONE until hpos=0.
//   6. During LOAD of sprite 1, change addr_in slice 1 from 3 to 7
//      -> rom_yofs follows on the next clk; req deasserting mid-line doesn't cancel the grant.

Source files
------------

// File: rtl/sprite_fetch_scheduler.sv
// sprite_fetch_scheduler: time-shares the sprite bitmap ROM among renderers during hblank
module sprite_fetch_scheduler #(
    parameter int NUM_SPRITES  = 4,
    parameter int ADDR_W       = 4,
    parameter int SLOT_CYCLES  = 4,
    parameter int HBLANK_START = 256,
    parameter int MAX_SLOTS    = 12
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [8:0]                    hpos,
    input  logic [NUM_SPRITES-1:0]        req,
    input  logic [NUM_SPRITES*ADDR_W-1:0] addr_in,
    output logic [NUM_SPRITES-1:0]        load,
    output logic [ADDR_W-1:0]             rom_yofs,
    output logic [2:0]                    active_id,
    output logic                          busy,
    output logic                          overrun
);
    localparam int CNT_W = SLOT_CYCLES > 1 ? $clog2(SLOT_CYCLES) : 1;
    localparam int SLOT_W = $clog2(MAX_SLOTS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(MAX_SLOTS - 1);
    localparam logic [3:0] N4 = 4'(NUM_SPRITES);
    localparam logic [2:0] ID_LAST = 3'(NUM_SPRITES - 1);
    localparam logic [8:0] HB = 9'(HBLANK_START);

    typedef enum logic [1:0] {IDLE, ARB, LOAD, DONE} state_t;

    state_t                 state;
    logic [2:0]             rr_ptr, rr_next, pick, off, sel;
    logic [3:0]             sum;
    logic [NUM_SPRITES-1:0] pending, rot, pick_oh, active_oh, pending_left;
    logic [SLOT_W-1:0]      slots;
    logic [CNT_W-1:0]       cnt;
    logic [ADDR_W-1:0]      sel_addr;

    // round-robin pick: rotate pending so rr_ptr lands at bit 0, take the lowest set bit, rotate back
    always_comb begin
        rot = NUM_SPRITES'({pending, pending} >> rr_ptr);
        off = 3'd0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--)
            if (rot[i]) off = 3'(i);
        sum = {1'b0, rr_ptr} + {1'b0, off};
        pick = sum >= N4 ? 3'(sum - N4) : sum[2:0];
        pick_oh = NUM_SPRITES'(1) << pick;
        active_oh = NUM_SPRITES'(1) << active_id;
        pending_left = pending & ~active_oh;
        rr_next = rr_ptr == ID_LAST ? 3'd0 : rr_ptr + 3'd1;
        sel = state == ARB ? pick : active_id;
        sel_addr = ADDR_W'(addr_in >> (sel * ADDR_W));
    end

    // fetch FSM: snapshot at hblank, grant one load window at a time, rotate priority per line
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            load      <= '0;
            rom_yofs  <= '0;
            active_id <= 3'd0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
            rr_ptr    <= 3'd0;
            pending   <= '0;
            slots     <= '0;
            cnt       <= '0;
        end else begin
            overrun <= 1'b0;
            case (state)
                IDLE: if (hpos == HB) begin
                    pending <= req;
                    slots   <= '0;
                    busy    <= 1'b1;
                    state   <= ARB;
                end
                ARB: if (pending == '0) begin
                    busy   <= 1'b0;
                    rr_ptr <= rr_next;
                    state  <= DONE;
                end else begin
                    active_id <= pick;
                    cnt       <= '0;
                    load      <= pick_oh;
                    rom_yofs  <= sel_addr;
                    state     <= LOAD;
                end
                LOAD: if (cnt == CNT_LAST) begin
                    pending  <= pending_left;
                    slots    <= slots + 1'b1;
                    load     <= '0;
                    rom_yofs <= '0;
                    if (slots == SLOT_LAST || pending_left == '0) begin
                        busy    <= 1'b0;
                        rr_ptr  <= rr_next;
                        overrun <= |pending_left;
                        state   <= DONE;
                    end else begin
                        state <= ARB;
                    end
                end else begin
                    cnt      <= cnt + 1'b1;
                    rom_yofs <= sel_addr;
                end
                DONE: if (hpos == 9'd0) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sprite_fetch_scheduler.sv
// tb_sprite_fetch_scheduler: scoreboard bench for the hblank ROM fetch scheduler
`timescale 1ns/1ps
module tb_sprite_fetch_scheduler;
    localparam int N = 4, AW = 4, SC = 4, LINE = 320;

    logic          clk = 0, reset = 1;
    logic [8:0]    hpos = 0;
    logic [N-1:0]  req = 0, req2 = 0;
    logic [N*AW-1:0] addr_in = 16'h9531;
    logic [N-1:0]  load, load2;
    logic [AW-1:0] rom_yofs, rom_yofs2;
    logic [2:0]    active_id, active_id2;
    logic          busy, busy2, overrun, overrun2;
    int            tests = 0, fails = 0;
    bit            mon_en = 0;

    typedef struct {int id; int start;} grant_t;
    grant_t exp_q[$];

    sprite_fetch_scheduler dut (
        .clk(clk), .reset(reset), .hpos(hpos), .req(req), .addr_in(addr_in),
        .load(load), .rom_yofs(rom_yofs), .active_id(active_id), .busy(busy), .overrun(overrun)
    );

    sprite_fetch_scheduler #(.MAX_SLOTS(2)) dut2 (
        .clk(clk), .reset(reset), .hpos(hpos), .req(req2), .addr_in(addr_in),
        .load(load2), .rom_yofs(rom_yofs2), .active_id(active_id2), .busy(busy2), .overrun(overrun2)
    );

    always #5 clk = ~clk;

    // free-running horizontal counter, 320 clocks per line
    initial forever begin
        @(posedge clk);
        #1 hpos = hpos == 9'(LINE - 1) ? 9'd0 : hpos + 9'd1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

    // scoreboard monitor: each grant start pops an expected (id, start hpos), each end checks its length
    initial begin
        logic [N-1:0] prev;
        int len;
        grant_t g;
        prev = '0;
        len = 0;
        forever begin
            @(negedge clk);
            if (reset || !mon_en) begin
                prev = '0;
                len = 0;
            end else begin
                if (load != '0 && prev == '0) begin
                    tests++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL sb_unexpected: load=%b at hpos=%0d, required no grant", load, hpos);
                    end else begin
                        g = exp_q.pop_front();
                        if (load !== (N'(1) << g.id) || hpos !== 9'(g.start)) begin
                            fails++;
                            $display("FAIL sb_grant: load=%b at hpos=%0d, required load=%b at hpos=%0d",
                                     load, hpos, N'(1) << g.id, g.start);
                        end
                    end
                    len = 1;
                end else if (load != '0) begin
                    len++;
                end else if (prev != '0) begin
                    tests++;
                    if (len !== SC) begin
                        fails++;
                        $display("FAIL sb_length: window=%0d clks, required %0d", len, SC);
                    end
                end
                prev = load;
            end
        end
    end

    task automatic wait_hpos(input int v);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (hpos != 9'(v) && n < 2 * LINE);
        if (hpos != 9'(v)) begin
            tests++;
            fails++;
            $display("FAIL wait_hpos: hpos=%0d, required %0d", hpos, v);
        end
    endtask

    task automatic check_drained(input string name);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s_missing: %0d grants outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset;
        reset = 1;
        repeat (3) @(negedge clk);
        tests++;
        if ({load, rom_yofs, active_id, busy, overrun} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: %h, required 0", {load, rom_yofs, active_id, busy, overrun});
        end
        tests++;
        if ({load2, rom_yofs2, active_id2, busy2, overrun2} !== '0) begin
            fails++;
            $display("FAIL reset_outputs2: %h, required 0", {load2, rom_yofs2, active_id2, busy2, overrun2});
        end
        reset = 0;
    endtask

    task automatic test_reset_mid_load;
        int bad = 0;
        wait_hpos(250);
        req = 4'b0011;
        wait_hpos(258);
        tests++;
        if (load !== 4'b0001 || busy !== 1'b1) begin
            fails++;
            $display("FAIL pre_reset_load: load=%b busy=%b, required 0001/1", load, busy);
        end
        reset = 1;
        #1;
        tests++;
        if (load !== '0 || busy !== 1'b0 || rom_yofs !== '0) begin
            fails++;
            $display("FAIL async_reset: load=%b busy=%b yofs=%0d, required 0/0/0", load, busy, rom_yofs);
        end
        @(negedge clk);
        reset = 0;
        do begin
            @(negedge clk);
            if (load != '0 || busy) bad++;
        end while (hpos != 9'd249);
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL no_regrant: %0d active clks after reset, required 0", bad);
        end
        mon_en = 1;
    endtask

    task automatic test_two_grants;
        wait_hpos(250);
        req = 4'b0101;
        exp_q.push_back(grant_t'{0, 258});
        exp_q.push_back(grant_t'{2, 263});
        wait_hpos(258);
        tests++;
        if (rom_yofs !== 4'd1 || active_id !== 3'd0) begin
            fails++;
            $display("FAIL two_yofs0: yofs=%0d id=%0d, required 1/0", rom_yofs, active_id);
        end
        wait_hpos(262);
        tests++;
        if (load !== '0 || busy !== 1'b1 || rom_yofs !== '0) begin
            fails++;
            $display("FAIL two_gap: load=%b busy=%b yofs=%0d, required 0/1/0", load, busy, rom_yofs);
        end
        wait_hpos(263);
        tests++;
        if (rom_yofs !== 4'd5 || active_id !== 3'd2) begin
            fails++;
            $display("FAIL two_yofs2: yofs=%0d id=%0d, required 5/2", rom_yofs, active_id);
        end
        wait_hpos(267);
        tests++;
        if (busy !== 1'b0 || overrun !== 1'b0 || load !== '0) begin
            fails++;
            $display("FAIL two_done: busy=%b overrun=%b load=%b, required 0/0/0", busy, overrun, load);
        end
        wait_hpos(300);
        check_drained("two");
    endtask

    task automatic test_rotation;
        wait_hpos(250);
        exp_q.push_back(grant_t'{2, 258});
        exp_q.push_back(grant_t'{0, 263});
        wait_hpos(258);
        tests++;
        if (rom_yofs !== 4'd5) begin
            fails++;
            $display("FAIL rot_yofs: yofs=%0d, required 5", rom_yofs);
        end
        wait_hpos(300);
        check_drained("rot");
    endtask

    task automatic test_addr_follow;
        wait_hpos(250);
        req = 4'b0010;
        exp_q.push_back(grant_t'{1, 258});
        wait_hpos(258);
        tests++;
        if (rom_yofs !== 4'd3) begin
            fails++;
            $display("FAIL follow_first: yofs=%0d, required 3", rom_yofs);
        end
        wait_hpos(259);
        tests++;
        if (rom_yofs !== 4'd3) begin
            fails++;
            $display("FAIL follow_hold: yofs=%0d, required 3", rom_yofs);
        end
        addr_in = 16'h9571;
        req = 4'b0000;
        wait_hpos(260);
        tests++;
        if (rom_yofs !== 4'd7 || load !== 4'b0010) begin
            fails++;
            $display("FAIL follow_new: yofs=%0d load=%b, required 7/0010", rom_yofs, load);
        end
        wait_hpos(262);
        tests++;
        if (rom_yofs !== '0 || load !== '0) begin
            fails++;
            $display("FAIL follow_end: yofs=%0d load=%b, required 0/0", rom_yofs, load);
        end
        wait_hpos(300);
        check_drained("follow");
        addr_in = 16'h9531;
    endtask

    task automatic test_no_req;
        int bad = 0;
        wait_hpos(257);
        tests++;
        if (busy !== 1'b1 || load !== '0) begin
            fails++;
            $display("FAIL noreq_arb: busy=%b load=%b, required 1/0", busy, load);
        end
        do begin
            @(negedge clk);
            if (busy || overrun || load != '0) bad++;
        end while (hpos != 9'(LINE - 1));
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL noreq_done: %0d active clks, required 0", bad);
        end
    endtask

    task automatic test_back_to_back;
        wait_hpos(250);
        req = 4'b1111;
        for (int i = 0; i < N; i++) exp_q.push_back(grant_t'{i, 258 + 5 * i});
        wait_hpos(277);
        tests++;
        if (busy !== 1'b0 || overrun !== 1'b0) begin
            fails++;
            $display("FAIL b2b_done: busy=%b overrun=%b, required 0/0", busy, overrun);
        end
        wait_hpos(300);
        check_drained("b2b");
        req = 4'b0000;
    endtask

    task automatic test_max_slots;
        for (int ln = 0; ln < 2; ln++) begin
            logic [N-1:0] first, second, exp_first, exp_second;
            logic ov_at;
            int pulses = 0, act = 0;
            first = '0;
            second = '0;
            ov_at = 1'b0;
            exp_first = ln == 0 ? 4'b0010 : 4'b0100;
            exp_second = ln == 0 ? 4'b0100 : 4'b1000;
            wait_hpos(250);
            req2 = 4'b1111;
            do begin
                @(negedge clk);
                if (overrun2) pulses++;
                if (load2 != '0) act++;
                if (hpos == 9'd258) first = load2;
                if (hpos == 9'd263) second = load2;
                if (hpos == 9'd267) ov_at = overrun2;
            end while (hpos != 9'd300);
            tests++;
            if (first !== exp_first || second !== exp_second) begin
                fails++;
                $display("FAIL max_order%0d: grants %b,%b, required %b,%b", ln, first, second, exp_first, exp_second);
            end
            tests++;
            if (act !== 2 * SC) begin
                fails++;
                $display("FAIL max_count%0d: %0d load clks, required %0d", ln, act, 2 * SC);
            end
            tests++;
            if (pulses !== 1 || ov_at !== 1'b1) begin
                fails++;
                $display("FAIL max_overrun%0d: %0d pulses, at267=%b, required 1/1", ln, pulses, ov_at);
            end
        end
        req2 = 4'b0000;
    endtask

    initial begin
        test_reset;
        test_reset_mid_load;
        test_two_grants;
        test_rotation;
        test_addr_follow;
        test_no_req;
        test_back_to_back;
        test_max_slots;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
